spi_responder: RTL
==================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 12, giving the frame length in bits.
- REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sclk, cs and mosi.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its posedge.
- REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port sclk, input, 1 bit: asynchronous serial clock from the master.
- REQ-006 The block SHALL have port cs, input, 1 bit: asynchronous chip select, active-low.
- REQ-007 The block SHALL have port mosi, input, 1 bit: asynchronous serial data from the master.
- REQ-008 The block SHALL have port tx_data, input, WIDTH bits: response word for the next frame.
- REQ-009 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
- REQ-010 The block SHALL have port tx_ready, output, 1 bit: the response buffer can accept a word.
- REQ-011 The block SHALL have port miso, output, 1 bit: serial response data.
- REQ-012 The block SHALL have port dout, output, WIDTH bits: last complete received word.
- REQ-013 The block SHALL have port done, output, 1 bit: one-clk pulse when dout is updated.
- REQ-014 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on a short frame.

Function
- REQ-015 sclk, cs and mosi SHALL each pass through a SYNC_STAGES flop synchronizer before use; sclk edges SHALL be detected by comparing the synchronized sample with its previous value.
- REQ-016 Protocol: the master updates mosi on the sclk rising edge, and data is LSB first.
- REQ-017 The responder SHALL sample mosi on each detected sclk falling edge, shifting as rx <= {mosi, rx[WIDTH-1:1]}.
- REQ-018 The FSM SHALL have states IDLE, SHIFT and WAIT_CS.
- REQ-019 IDLE -> SHIFT on synchronized cs falling; at the same time the bit counter SHALL clear, the tx buffer SHALL copy into the tx shift register (or zero if empty), and miso SHALL be driven with bit 0.
- REQ-020 In SHIFT, each sclk falling edge SHALL increment the bit counter (width clog2(WIDTH+1)).
- REQ-021 In SHIFT, each sclk rising edge after the first falling edge SHALL shift the tx register right and drive the new bit 0 on miso.
- REQ-022 On the WIDTH-th falling edge, the FSM SHALL load dout with the completed word, pulse done for exactly one clk, and go to WAIT_CS.
- REQ-023 In WAIT_CS, further sclk edges SHALL be ignored, and dout and miso SHALL hold; on cs high the FSM SHALL go to IDLE and miso SHALL be driven 0.
- REQ-024 If cs rises in SHIFT before WIDTH bits are received, the block SHALL pulse frame_err for one clk, leave dout unchanged, pulse no done, and return to IDLE.
- REQ-025 tx handshake: when tx_valid && tx_ready, tx_data SHALL load the tx buffer and tx_ready SHALL go 0 on the next clk.
- REQ-026 tx_ready SHALL return to 1 in the clk after a frame start consumes the buffer.
- REQ-027 A load during an active frame SHALL affect only the next frame.
- REQ-028 If a frame start and a buffer load coincide, the frame SHALL take the old buffer contents (or zero if empty), and the new word SHALL be retained for the next frame.
- REQ-029 The minimum supported sclk half-period SHALL be SYNC_STAGES+2 clk cycles; faster sclk is unsupported and undefined.
- REQ-030 dout latency SHALL be at most SYNC_STAGES+2 clk cycles after the final sclk falling edge.

Reset
- REQ-031 While rst=1 at a clk posedge, the block SHALL set state IDLE, dout=0, done=0, frame_err=0, miso=0, tx_ready=1, tx buffer empty, counters=0, and synchronizers to idle levels (sclk 0, cs 1, mosi 0).
- REQ-032 A reset asserted mid-frame SHALL discard the partial word and pulse neither done nor frame_err.
- REQ-033 After a mid-frame reset, the block SHALL wait in IDLE for a fresh cs falling edge; if cs is still low after reset, that frame SHALL be ignored until cs goes high.

Structure
- REQ-034 Package spi_pkg SHALL hold the FSM state enum and the default frame width constant 12, shared with the master.
- REQ-035 Sub-module spi_sync, a parameterized-depth single-bit synchronizer, SHALL be instantiated three times.

Verification
- REQ-036 Load tx 12'h3C1, then master sends 12'hA5C -> dout=12'hA5C, one done pulse, and miso captured LSB-first = 12'h3C1.
- REQ-037 No tx load, then a frame 12'hFFF -> dout=12'hFFF, and miso is 0 for all 12 bits.
- REQ-038 cs rises after 5 bits -> frame_err one pulse, no done, dout keeps its prior value, and the next full frame 12'h123 is received correctly.
- REQ-039 rst pulsed after 7 bits of 12'h555 -> all outputs at reset values, no done, and the following frame 12'h0AA gives dout=12'h0AA.
- REQ-040 Back-to-back frames 12'h001 and 12'h800 with tx 12'h00F, then 12'hF00 loaded mid-frame 1 -> two done pulses, miso words 12'h00F and 12'hF00, and tx_ready timing per REQ-025 to REQ-028.
- REQ-041 14 sclk cycles in one cs-low window -> dout holds the first 12 bits, and extra edges are ignored.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width default and responder FSM states.
package spi_pkg;

    localparam int SPI_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit flop synchronizer of parameterized depth with a reset level.
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {STAGES{INIT}};
        end else begin
            ff <= STAGES'({ff, d});
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI responder: LSB-first, master drives on sclk rise, we sample on fall.
module spi_responder
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             miso,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_q;
    logic cs_q;

    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .rst(rst), .d(cs), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] tx_buf;
    logic             buf_full;
    logic [SYNC_STAGES:0] warm;
    logic             armed;

    logic sclk_rise;
    logic sclk_fall;
    logic start;
    logic load;

    // A cs already low when reset lifts must be seen high before it can open a frame.
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign start     = (state == IDLE) & armed & cs_q & ~cs_s;
    assign load      = tx_valid & ~buf_full;
    assign tx_ready  = ~buf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rx        <= '0;
            tx_sh     <= '0;
            tx_buf    <= '0;
            buf_full  <= 1'b0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            miso      <= 1'b0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            warm      <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (warm[SYNC_STAGES] & cs_s);
            done      <= 1'b0;
            frame_err <= 1'b0;

            if (load) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end else if (start) begin
                buf_full <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        tx_sh <= buf_full ? tx_buf : '0;
                        miso  <= buf_full & tx_buf[0];
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            rx  <= {mosi_s, rx[WIDTH-1:1]};
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(WIDTH - 1)) begin
                                dout  <= {mosi_s, rx[WIDTH-1:1]};
                                done  <= 1'b1;
                                state <= WAIT_CS;
                            end
                        end
                        if (sclk_rise && cnt != '0) begin
                            tx_sh <= tx_sh >> 1;
                            miso  <= tx_sh[1];
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_s) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
